// File: rtl/collector_pkg.sv
// collector_pkg
//   Shared constants and state encodings for the collector (encrypter-array
//   drain stage) and its word FIFO.
//   ENCRYPTER_WIDTH  word width produced by each encrypter lane
//   COLLECTOR_BYTES  bytes per word emitted by the serializer
//   cap_state_e      capture FSM encodings (WAIT_READY / WAIT_RELEASE)
//   ser_state_e      serializer encodings
package collector_pkg;

    localparam int ENCRYPTER_WIDTH = 32;
    localparam int COLLECTOR_BYTES = ENCRYPTER_WIDTH / 8;

    typedef enum logic {
        COLLECTOR_WAIT_READY   = 1'b0,
        COLLECTOR_WAIT_RELEASE = 1'b1
    } cap_state_e;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_LOAD = 2'd1,
        SER_SEND = 2'd2
    } ser_state_e;

endpackage

// File: rtl/collector_fifo.sv
// collector_fifo
//   Synchronous word FIFO, WIDTH x DEPTH (DEPTH a power of 2, >= 2).
//   Full/empty are registered. Push while full and pop while empty are
//   ignored; simultaneous push and pop are both honoured. No bypass: a word
//   pushed on an edge is visible on rdata only after that edge.
// Ports
//   clk, reset       clock, synchronous active-high reset
//   push, wdata      write strobe and data
//   pop, rdata       read strobe and head-of-queue data
//   full, empty      registered occupancy flags
module collector_fifo
    import collector_pkg::*;
#(
    parameter int WIDTH = ENCRYPTER_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/collector.sv
// collector
//   Drains NUM_ENC encrypter lanes in strict round-robin order with a 4-phase
//   data_ready/capture handshake, buffers words in collector_fifo and emits
//   them LSB-byte-first on a valid/ready byte stream.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   data_in_c         lane i word at [i*WIDTH +: WIDTH]
//   data_ready_in_c   lane i holds a valid word
//   capture_c         capture acknowledge, at most one bit high
//   byte_out          output byte
//   byte_valid        byte_out valid
//   byte_ready        sink accepts byte_out this cycle
//   busy              FIFO non-empty | serializer active | capture in progress
//   words_captured    (COLLECTOR_STATS_EN only) saturating FIFO-write count
//   stall_cycles      (COLLECTOR_STATS_EN only) saturating full-stall count
// Configuration macro: COLLECTOR_STATS_EN
//
// Capture FSM
//   state        | meaning
//   WAIT_READY   | waiting for data_ready on lane_sel with FIFO not full
//   WAIT_RELEASE | capture_c held until lane_sel drops data_ready
// Serializer
//   state        | meaning
//   SER_IDLE     | no word held
//   SER_LOAD     | word just popped; byte_valid rises on the next edge
//   SER_SEND     | byte_valid high, shifting one byte per accepted transfer
module collector
    import collector_pkg::*;
#(
    parameter int NUM_ENC    = 4,
    parameter int WIDTH      = ENCRYPTER_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_ENC*WIDTH-1:0] data_in_c,
    input  logic [NUM_ENC-1:0]       data_ready_in_c,
    output logic [NUM_ENC-1:0]       capture_c,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     busy
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [15:0]              words_captured,
    output logic [15:0]              stall_cycles
`endif
);

    localparam int NBYTES = WIDTH / 8;
    localparam int SELW   = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam int CNTW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [SELW-1:0] LAST_LANE = SELW'(NUM_ENC - 1);
    localparam logic [CNTW-1:0] LAST_BYTE = CNTW'(NBYTES - 1);

    cap_state_e         cap_state_q;
    logic [SELW-1:0]    lane_sel_q;
    logic [NUM_ENC-1:0] capture_q;
    logic               lane_ready;
    logic [WIDTH-1:0]   lane_word;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WIDTH-1:0]   fifo_rdata;

    ser_state_e         ser_state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNTW-1:0]    byte_cnt_q;
    logic               byte_valid_q;
    logic               last_accept;

    assign lane_ready = data_ready_in_c[lane_sel_q];
    assign lane_word  = data_in_c[int'(lane_sel_q)*WIDTH +: WIDTH];

    assign fifo_push = (cap_state_q == COLLECTOR_WAIT_READY) && lane_ready && !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_state_q <= COLLECTOR_WAIT_READY;
            lane_sel_q  <= '0;
            capture_q   <= '0;
        end else begin
            unique case (cap_state_q)
                COLLECTOR_WAIT_READY: begin
                    if (fifo_push) begin
                        capture_q   <= NUM_ENC'(1) << lane_sel_q;
                        cap_state_q <= COLLECTOR_WAIT_RELEASE;
                    end
                end
                COLLECTOR_WAIT_RELEASE: begin
                    if (!lane_ready) begin
                        capture_q   <= '0;
                        lane_sel_q  <= (lane_sel_q == LAST_LANE) ? '0 : lane_sel_q + 1'b1;
                        cap_state_q <= COLLECTOR_WAIT_READY;
                    end
                end
                default: cap_state_q <= COLLECTOR_WAIT_READY;
            endcase
        end
    end

    collector_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (lane_word),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Final byte leaving on this edge: refill in the same edge so the stream
    // has no bubble between words.
    assign last_accept = (ser_state_q == SER_SEND) && byte_ready && (byte_cnt_q == LAST_BYTE);
    assign fifo_pop    = !fifo_empty && ((ser_state_q == SER_IDLE) || last_accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            ser_state_q  <= SER_IDLE;
            shreg_q      <= '0;
            byte_cnt_q   <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            unique case (ser_state_q)
                SER_IDLE: begin
                    if (fifo_pop) begin
                        shreg_q     <= fifo_rdata;
                        byte_cnt_q  <= '0;
                        ser_state_q <= SER_LOAD;
                    end
                end
                SER_LOAD: begin
                    byte_valid_q <= 1'b1;
                    ser_state_q  <= SER_SEND;
                end
                SER_SEND: begin
                    if (byte_ready) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            if (fifo_pop) begin
                                shreg_q    <= fifo_rdata;
                                byte_cnt_q <= '0;
                            end else begin
                                byte_valid_q <= 1'b0;
                                ser_state_q  <= SER_IDLE;
                            end
                        end else begin
                            shreg_q    <= shreg_q >> 8;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                default: ser_state_q <= SER_IDLE;
            endcase
        end
    end

    assign capture_c  = capture_q;
    assign byte_out   = shreg_q[7:0];
    assign byte_valid = byte_valid_q;
    assign busy       = !fifo_empty || (ser_state_q != SER_IDLE) ||
                        (cap_state_q != COLLECTOR_WAIT_READY);

`ifdef COLLECTOR_STATS_EN
    logic        stall_now;
    logic [15:0] words_captured_q;
    logic [15:0] stall_cycles_q;

    assign stall_now = (cap_state_q == COLLECTOR_WAIT_READY) && lane_ready && fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            words_captured_q <= '0;
            stall_cycles_q   <= '0;
        end else begin
            if (fifo_push && (words_captured_q != 16'hFFFF)) begin
                words_captured_q <= words_captured_q + 16'd1;
            end
            if (stall_now && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign words_captured = words_captured_q;
    assign stall_cycles   = stall_cycles_q;
`endif

endmodule

// File: tb/tb_collector.sv
module tb_collector;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] data_in_c;
    logic [N-1:0]   rdy;
    logic [N-1:0]   cap;
    logic [7:0]     bo;
    logic           bv;
    logic           br;
    logic           busy;
`ifdef COLLECTOR_STATS_EN
    logic [15:0]    wc;
    logic [15:0]    sc;
`endif

    collector #(.NUM_ENC(N), .WIDTH(W), .FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in_c       (data_in_c),
        .data_ready_in_c (rdy),
        .capture_c       (cap),
        .byte_out        (bo),
        .byte_valid      (bv),
        .byte_ready      (br),
        .busy            (busy)
`ifdef COLLECTOR_STATS_EN
        ,
        .words_captured  (wc),
        .stall_cycles    (sc)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // encrypter lane model: per-lane word list, optional extra hold cycles
    logic [31:0] lw [N][16];
    int          lhead [N];
    int          ltail [N];
    int          hold [N];
    int          cap_rise [N];
    int          cap_hi [N];
    int          cap_order [$];
    logic [N-1:0] cap_prev;
    logic [7:0]  got [$];
    int          onehot_bad = 0;
    int          stable_bad = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_bo = 8'h00;

    localparam logic [7:0] EXP1 [16] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                                         8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h00, 8'hFF, 8'hEE, 8'hDD};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log a byte that the coming edge accepts, then observe and
    // update the lanes at the following negedge.
    task automatic cyc();
        if (stall_prev && (!bv || bo !== prev_bo)) stable_bad++;
        stall_prev = bv && !br && !reset;
        prev_bo = bo;
        if (bv && br) got.push_back(bo);
        @(posedge clk);
        @(negedge clk);
        if (!$onehot0(cap)) onehot_bad++;
        for (int i = 0; i < N; i++) begin
            if (cap[i] && !cap_prev[i]) begin
                cap_rise[i]++;
                cap_order.push_back(i);
            end
            if (cap[i]) cap_hi[i]++;
        end
        cap_prev = cap;
        for (int i = 0; i < N; i++) begin
            if (rdy[i] && cap[i]) begin
                if (hold[i] > 0) hold[i]--;
                else begin
                    rdy[i] = 1'b0;
                    lhead[i]++;
                end
            end else if (!rdy[i] && !cap[i] && lhead[i] != ltail[i]) begin
                rdy[i] = 1'b1;
                data_in_c[i*W +: W] = lw[i][lhead[i]];
            end
        end
    endtask

    task automatic push_word(input int lane, input logic [31:0] w);
        lw[lane][ltail[lane]] = w;
        ltail[lane]++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        br = 1'b0;
        data_in_c = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = 1'b0;
            lhead[i] = 0;
            ltail[i] = 0;
            hold[i] = 0;
            cap_rise[i] = 0;
            cap_hi[i] = 0;
        end
        cyc();
        cyc();
        reset = 1'b0;
        got.delete();
        cap_order.delete();
    endtask

    task automatic wait_bytes(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (got.size() < n && k < limit) begin
            cyc();
            k++;
        end
        chk(tag, 32'(got.size()), 32'(n));
    endtask

    task automatic wait_rise(input int lane, input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (cap_rise[lane] < n && k < limit) begin
            cyc();
            k++;
        end
        chk(tag, 32'(cap_rise[lane]), 32'(n));
    endtask

    initial begin
        cap_prev = '0;
        rdy = '0;
        br = 1'b0;
        data_in_c = '0;
        reset = 1'b1;
        @(negedge clk);

        // reset state
        do_reset();
        chk("rst_cap", 32'(cap), 0);
        chk("rst_valid", 32'(bv), 0);
        chk("rst_byte", 32'(bo), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lane_sel", 32'(dut.lane_sel_q), 0);
        chk("rst_fifo_empty", 32'(dut.fifo_empty), 1);
`ifdef COLLECTOR_STATS_EN
        chk("rst_words_captured", 32'(wc), 0);
        chk("rst_stall_cycles", 32'(sc), 0);
`endif

        // 1: four lanes, round robin, latency T -> T+2
        push_word(0, 32'h11223344);
        push_word(1, 32'h55667788);
        push_word(2, 32'h99AABBCC);
        push_word(3, 32'hDDEEFF00);
        br = 1'b1;
        cyc();
        wait_rise(0, 1, 10, "t1_cap0");
        chk("t1_lat_T", 32'(bv), 0);
        cyc();
        chk("t1_lat_T1", 32'(bv), 0);
        cyc();
        chk("t1_lat_T2_valid", 32'(bv), 1);
        chk("t1_lat_T2_byte", 32'(bo), 32'h44);
        wait_bytes(16, 200, "t1_count");
        for (int j = 0; j < 16; j++) chk($sformatf("t1_byte%0d", j), 32'(got[j]), 32'(EXP1[j]));
        chk("t1_order_size", 32'(cap_order.size()), 4);
        for (int j = 0; j < 4; j++) chk($sformatf("t1_order%0d", j), 32'(cap_order[j]), 32'(j));
        repeat (4) cyc();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_valid", 32'(bv), 0);

        // 2: lane 2 ready before lane 1 waits its turn
        do_reset();
        br = 1'b1;
        push_word(0, 32'h03020100);
        push_word(2, 32'h0B0A0908);
        repeat (12) cyc();
        chk("t2_cap0", 32'(cap_rise[0]), 1);
        chk("t2_no_cap2", 32'(cap_rise[2]), 0);
        push_word(1, 32'h07060504);
        wait_bytes(12, 200, "t2_count");
        for (int j = 0; j < 12; j++) chk($sformatf("t2_byte%0d", j), 32'(got[j]), 32'(j));
        chk("t2_order_size", 32'(cap_order.size()), 3);
        for (int j = 0; j < 3; j++) chk($sformatf("t2_order%0d", j), 32'(cap_order[j]), 32'(j));

        // 3: lane 0 holds data_ready after capture
        do_reset();
        br = 1'b1;
        hold[0] = 4;
        push_word(0, 32'h13121110);
        push_word(1, 32'h17161514);
        wait_bytes(8, 200, "t3_count");
        repeat (10) cyc();
        chk("t3_cap_high_cycles", 32'(cap_hi[0]), 5);
        chk("t3_cap0_once", 32'(cap_rise[0]), 1);
        chk("t3_no_dup_bytes", 32'(got.size()), 8);
        for (int j = 0; j < 8; j++) chk($sformatf("t3_byte%0d", j), 32'(got[j]), 32'(8'h10 + j));
        chk("t3_order_size", 32'(cap_order.size()), 2);
        chk("t3_lane_sel", 32'(dut.lane_sel_q), 2);

        // 4/6: FIFO full with byte_ready low, then drain
        do_reset();
        for (int k = 0; k < 9; k++) begin
            push_word(k % N, {8'(8'h13 + 4*k), 8'(8'h12 + 4*k), 8'(8'h11 + 4*k), 8'(8'h10 + 4*k)});
        end
        repeat (40) cyc();
        chk("t4_captured9", 32'(cap_rise[0] + cap_rise[1] + cap_rise[2] + cap_rise[3]), 9);
        chk("t4_fifo_full", 32'(dut.fifo_full), 1);
        chk("t4_held_byte", 32'(bo), 32'h10);
        chk("t4_held_valid", 32'(bv), 1);
        push_word(1, 32'h37363534);
        cyc();
        repeat (6) cyc();
        chk("t4_stall_no_cap", 32'(cap), 0);
        chk("t4_stall_lane1", 32'(cap_rise[1]), 2);
        chk("t4_busy", 32'(busy), 1);
`ifdef COLLECTOR_STATS_EN
        chk("t6_words_at_stall", 32'(wc), 9);
        chk("t6_stall_partial", 32'(sc), 6);
`endif
        br = 1'b1;
        wait_bytes(40, 300, "t4_count");
        for (int j = 0; j < 40; j++) chk($sformatf("t4_byte%0d", j), 32'(got[j]), 32'(8'h10 + j));
        repeat (6) cyc();
        chk("t4_no_extra", 32'(got.size()), 40);
`ifdef COLLECTOR_STATS_EN
        chk("t6_words_final", 32'(wc), 10);
        chk("t6_stall_final", 32'(sc), 10);
`endif

        // 5: reset during WAIT_RELEASE and mid-word
        do_reset();
        hold[2] = 20;
        push_word(0, 32'h23222120);
        push_word(1, 32'h27262524);
        push_word(2, 32'h2B2A2928);
        wait_rise(2, 1, 60, "t5_cap2");
        cyc();
        br = 1'b1;
        cyc();
        br = 1'b0;
        cyc();
        chk("t5_pre_cap", 32'(cap), 32'h4);
        chk("t5_pre_valid", 32'(bv), 1);
        chk("t5_pre_byte", 32'(bo), 32'h21);
        reset = 1'b1;
        cyc();
        chk("t5_cap", 32'(cap), 0);
        chk("t5_valid", 32'(bv), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_lane_sel", 32'(dut.lane_sel_q), 0);
        chk("t5_fifo_empty", 32'(dut.fifo_empty), 1);
        do_reset();
        br = 1'b1;
        push_word(0, 32'h33323130);
        push_word(1, 32'h37363534);
        wait_bytes(8, 200, "t5_post_count");
        for (int j = 0; j < 8; j++) chk($sformatf("t5_post_byte%0d", j), 32'(got[j]), 32'(8'h30 + j));
        chk("t5_post_first_lane", 32'(cap_order[0]), 0);

        chk("onehot_capture", 32'(onehot_bad), 0);
        chk("stable_while_stalled", 32'(stable_bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
